icc_flag_register: RTL

- Producer side of the integer condition codes. Owns PSR.icc (N,Z,V,C) and drives it to the branch/trap condition evaluator.
- Updates flags from ALU results of cc-setting instructions (addcc, addxcc, subcc, subxcc, logical-cc, taddcc, tsubcc).
- Applies WRPSR icc writes after the architectural delay, implemented as a countdown.
- Sits in the writeback stage, beside the PSR/WIM register block.

---
 rtl/icc_flag_register_if.sv | 31 +++
 rtl/icc_flag_register.sv | 124 ++++++++++++
 2 files changed

// File: rtl/icc_flag_register_if.sv
// rtl/icc_flag_register_if.sv - ALU/WRPSR inputs and icc outputs of the integer condition-code register
interface icc_flag_register_if #(
    parameter int OPC_W = 3
);
    logic             stall;
    logic             cc_we;
    logic [OPC_W-1:0] op_class;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_r;
    logic             alu_cout;
    logic             wrpsr_we;
    logic [3:0]       wrpsr_icc;
    logic             n;
    logic             z;
    logic             v;
    logic             c;
    logic [3:0]       icc;
    logic [3:0]       icc_fwd;
    logic             wrpsr_busy;

    modport master (
        output stall, cc_we, op_class, alu_a, alu_b, alu_r, alu_cout, wrpsr_we, wrpsr_icc,
        input  n, z, v, c, icc, icc_fwd, wrpsr_busy
    );

    modport slave (
        input  stall, cc_we, op_class, alu_a, alu_b, alu_r, alu_cout, wrpsr_we, wrpsr_icc,
        output n, z, v, c, icc, icc_fwd, wrpsr_busy
    );
endinterface

// File: rtl/icc_flag_register.sv
// rtl/icc_flag_register.sv - PSR.icc producer with ALU flag update and delayed WRPSR write (option: ICC_BYPASS_EN)
module icc_flag_register #(
    parameter int WRPSR_DELAY = 3,
    parameter int OPC_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    icc_flag_register_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ADDX  = 3'd1,
        OP_SUB   = 3'd2,
        OP_SUBX  = 3'd3,
        OP_LOGIC = 3'd4,
        OP_TADD  = 3'd5,
        OP_TSUB  = 3'd6,
        OP_RSVD  = 3'd7
    } op_class_e;

    localparam logic [2:0] DELAY_LD = 3'(WRPSR_DELAY);

    logic [3:0] icc_q, icc_d;
    logic [3:0] pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d;

    op_class_e  op;
    logic       a31, b31, r31;
    logic       v_add, v_sub, tag_err;
    logic       cc_v, cc_c;
    logic       cc_upd;
    logic       expire;
    logic [3:0] cc_flags;

    assign op  = op_class_e'(bus.op_class[2:0]);
    assign a31 = bus.alu_a[31];
    assign b31 = bus.alu_b[31];
    assign r31 = bus.alu_r[31];

    // B is un-inverted, so subtract overflow tests the opposite sign of B
    assign v_add   = (a31 & b31 & ~r31) | (~a31 & ~b31 & r31);
    assign v_sub   = (a31 & ~b31 & ~r31) | (~a31 & b31 & r31);
    assign tag_err = (|bus.alu_a[1:0]) | (|bus.alu_b[1:0]);

    always_comb begin
        cc_v = 1'b0;
        cc_c = 1'b0;
        case (op)
            OP_ADD, OP_ADDX: begin
                cc_v = v_add;
                cc_c = bus.alu_cout;
            end
            OP_SUB, OP_SUBX: begin
                cc_v = v_sub;
                cc_c = ~bus.alu_cout;
            end
            OP_TADD: begin
                cc_v = v_add | tag_err;
                cc_c = bus.alu_cout;
            end
            OP_TSUB: begin
                cc_v = v_sub | tag_err;
                cc_c = ~bus.alu_cout;
            end
            default: begin
                cc_v = 1'b0;
                cc_c = 1'b0;
            end
        endcase
    end

    assign cc_flags = {r31, (bus.alu_r == 32'd0), cc_v, cc_c};
    assign cc_upd   = bus.cc_we && (op != OP_RSVD);
    assign expire   = (cnt_q == 3'd1);

    // Ordering below gives WRPSR expiry priority over a same-cycle CC update,
    // and lets a new WRPSR reload after the expiring value has been applied.
    always_comb begin
        icc_d  = icc_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (!bus.stall) begin
            if (cc_upd) begin
                icc_d = cc_flags;
            end
            if (expire) begin
                icc_d = pend_q;
                cnt_d = 3'd0;
            end else if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end
            if (bus.wrpsr_we) begin
                pend_d = bus.wrpsr_icc;
                cnt_d  = DELAY_LD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icc_q  <= 4'b0000;
            pend_q <= 4'b0000;
            cnt_q  <= 3'd0;
        end else begin
            icc_q  <= icc_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.icc        = icc_q;
    assign bus.n          = icc_q[3];
    assign bus.z          = icc_q[2];
    assign bus.v          = icc_q[1];
    assign bus.c          = icc_q[0];
    assign bus.wrpsr_busy = (cnt_q != 3'd0);

`ifdef ICC_BYPASS_EN
    // icc_d already equals icc_q when nothing updates, so one mux covers all cases
    assign bus.icc_fwd = bus.stall ? icc_q : icc_d;
`else
    assign bus.icc_fwd = icc_q;
`endif
endmodule
